// File: rtl/data_mem_ls_if.sv
// data_mem_ls_if: request/response bundle for data_mem_ls.
// master drives requests, slave returns one response per request.
interface data_mem_ls_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/data_mem_ls.sv
// data_mem_ls: pipelined byte-addressed load/store data memory.
// Define DATA_MEM_INIT_SWEEP_EN to clear all words after reset.
module data_mem_ls #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  data_mem_ls_if.slave bus
);
  localparam int BYTES  = WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = IDX_W + OFF_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ready;
  logic             acc;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [3:0]       nbytes;
  logic             req_err;
  logic             st_we;
  logic [BYTES-1:0] be;
  logic [WIDTH-1:0] wsh;

`ifdef DATA_MEM_INIT_SWEEP_EN
  typedef enum logic {INIT, RUN} state_e;

  localparam logic [IDX_W:0] CNT_END = DEPTH[IDX_W:0];

  state_e         state_q, state_d;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic           sweep_we;

  // sweep state and clear-address counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // counter runs one past the last word so RUN starts a cycle later
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    ready    = 1'b0;
    unique case (state_q)
      INIT: begin
        if (cnt_q == CNT_END) begin
          state_d = RUN;
        end else begin
          sweep_we = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      RUN: ready = 1'b1;
      default: ;
    endcase
  end
`else
  logic rdy_q;

  // ready from the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign ready = rdy_q;
`endif

  assign bus.req_ready = ready;
  assign acc    = bus.req_valid && ready;
  assign idx    = bus.req_addr[ADDR_W-1:OFF_W];
  assign off    = bus.req_addr[OFF_W-1:0];
  assign nbytes = 4'd1 << bus.req_size;
  assign wsh    = bus.req_wdata << {off, 3'b000};

  // misaligned lane offset or access wider than a word
  always_comb begin
    logic [3:0] off4;
    off4    = 4'(off);
    req_err = (nbytes > 4'(BYTES))
           || ((off4 & (nbytes - 4'd1)) != 4'd0);
  end

  assign st_we = acc && bus.req_write && !req_err;

  // byte lanes touched by the access
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) begin
      be[b] = (b >= int'(off))
           && (b < int'(off) + int'(nbytes));
    end
  end

  // storage: clear sweep or byte-enabled store
  always_ff @(posedge clk) begin
`ifdef DATA_MEM_INIT_SWEEP_EN
    if (sweep_we) mem_q[cnt_q[IDX_W-1:0]] <= '0;
`endif
    if (st_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wsh[b*8 +: 8];
      end
    end
  end

  logic             v0_q, wr0_q, err0_q, uns0_q;
  logic [1:0]       sz0_q;
  logic [OFF_W-1:0] off0_q;
  logic [WIDTH-1:0] word0_q;

  // capture the addressed word and request info at accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q    <= 1'b0;
      wr0_q   <= 1'b0;
      err0_q  <= 1'b0;
      uns0_q  <= 1'b0;
      sz0_q   <= '0;
      off0_q  <= '0;
      word0_q <= '0;
    end else begin
      v0_q <= acc;
      if (acc) begin
        wr0_q   <= bus.req_write;
        err0_q  <= req_err;
        uns0_q  <= bus.req_unsigned;
        sz0_q   <= bus.req_size;
        off0_q  <= off;
        word0_q <= mem_q[idx];
      end
    end
  end

  logic [WIDTH-1:0] sh, ext, rd0;
  logic             sbit;
  int               nb;

  // right-align the lanes and extend; stores/errors read as 0
  always_comb begin
    sh = word0_q >> {off0_q, 3'b000};
    nb = 8 << sz0_q;
    unique case (sz0_q)
      2'd0:    sbit = sh[7];
      2'd1:    sbit = sh[15];
      2'd2:    sbit = sh[31];
      default: sbit = sh[WIDTH-1];
    endcase
    ext = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ext[i] = (i < nb) ? sh[i] : (sbit & ~uns0_q);
    end
    rd0 = (wr0_q || err0_q) ? '0 : ext;
  end

  logic [RD_LAT-1:0] vp_q;
  logic [RD_LAT-1:0] ep_q;
  logic [WIDTH-1:0]  dp_q [RD_LAT];

  // latency pipe; data stages only load with valid so outputs hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vp_q <= '0;
      ep_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dp_q[i] <= '0;
    end else begin
      vp_q[0] <= v0_q;
      if (v0_q) begin
        dp_q[0] <= rd0;
        ep_q[0] <= err0_q;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vp_q[i] <= vp_q[i-1];
        if (vp_q[i-1]) begin
          dp_q[i] <= dp_q[i-1];
          ep_q[i] <= ep_q[i-1];
        end
      end
    end
  end

  assign bus.rsp_valid = vp_q[RD_LAT-1];
  assign bus.rsp_rdata = dp_q[RD_LAT-1];
  assign bus.rsp_err   = ep_q[RD_LAT-1];
endmodule

// File: tb/tb_data_mem_ls.sv
// tb_data_mem_ls: scoreboard bench for data_mem_ls.
// Byte-array reference model; monitor checks data, error and latency.
module tb_data_mem_ls;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 12;
`ifdef DATA_MEM_INIT_SWEEP_EN
  localparam int EXP_RDY = DEPTH + 1;
`else
  localparam int EXP_RDY = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  data_mem_ls_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  data_mem_ls #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    longint      cyc;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        me;
  logic [7:0]  mb [4096];
  longint      cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference: memory as flat bytes, little-endian, plain arithmetic
  task automatic model(input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [11:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output bit err);
    int n;
    longint v;
    n = 1 << sz;
    err = (n > 4) || ((int'(a) % n) != 0);
    rd = '0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(mb[int'(a) + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1)))
      v -= longint'(1) << (8 * n);
    rd = v[31:0];
  endtask

  task automatic model_reset();
`ifdef DATA_MEM_INIT_SWEEP_EN
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
`endif
  endtask

  // call #1 after a rising edge; request accepted at the next edge
  task automatic issue(input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [11:0] a,
                       input logic [31:0] wd, input bit use_c,
                       input logic [31:0] c_rd, input bit c_err,
                       input string tag);
    exp_t e;
    logic [31:0] mrd;
    bit merr;
    model(wr, sz, uns, a, wd, mrd, merr);
    e.rd  = use_c ? c_rd : mrd;
    e.err = use_c ? c_err : merr;
    e.cyc = cyc + 1 + RD_LAT;
    e.tag = tag;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= DEPTH + 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.req_ready) begin
        k = i;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check({name, " ready_edges"}, 64'(k), 64'(EXP_RDY));
  endtask

  // monitor: every response must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        me = sb_q.pop_front();
        check({me.tag, " rdata"}, 64'(bus.rsp_rdata), 64'(me.rd));
        check({me.tag, " err"}, 64'(bus.rsp_err), 64'(me.err));
        check({me.tag, " cycle"}, 64'(cyc), 64'(me.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    model_reset();

    #1 reset_n = 1'b0;
    #3;
    check("rst req_ready", 64'(bus.req_ready), 64'd0);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst rsp_err", 64'(bus.rsp_err), 64'd0);
    repeat (3) @(posedge clk);

    // a store held during reset/INIT must be ignored
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 12'h028;
    bus.req_wdata = 32'h12345678;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("init");

`ifndef DATA_MEM_INIT_SWEEP_EN
    for (int a = 0; a < 256; a += 4)
      issue(1, 2, 0, 12'(a), 32'h0, 0, 0, 0, "preload");
    issue(1, 2, 0, 12'hFFC, 32'h0, 0, 0, 0, "preload");
`endif

    issue(0, 2, 0, 12'h000, 0, 1, 32'h0, 0, "LW_000");
    issue(0, 2, 0, 12'hFFC, 0, 1, 32'h0, 0, "LW_FFC");
    issue(0, 2, 0, 12'h028, 0, 1, 32'h0, 0, "LW_028_clean");
    issue(1, 2, 0, 12'h028, 32'hDEADBEEF, 1, 0, 0, "SW_028");
    issue(0, 2, 0, 12'h028, 0, 1, 32'hDEADBEEF, 0, "LW_028");
    issue(1, 0, 0, 12'h029, 32'h55, 1, 0, 0, "SB_029");
    issue(0, 2, 0, 12'h028, 0, 1, 32'hDEAD55EF, 0, "LW_028b");
    issue(0, 0, 0, 12'h02B, 0, 1, 32'hFFFFFFDE, 0, "LB_02B");
    issue(0, 0, 1, 12'h02B, 0, 1, 32'h000000DE, 0, "LBU_02B");
    issue(0, 1, 0, 12'h02A, 0, 1, 32'hFFFFDEAD, 0, "LH_02A");
    issue(0, 1, 1, 12'h02A, 0, 1, 32'h0000DEAD, 0, "LHU_02A");
    issue(1, 2, 0, 12'h02A, 32'hCAFEF00D, 1, 0, 1, "SW_02A_mis");
    issue(0, 1, 0, 12'h029, 0, 1, 32'h0, 1, "LH_029_mis");
    issue(0, 3, 0, 12'h030, 0, 1, 32'h0, 1, "LD_030_size");
    issue(1, 3, 0, 12'h028, 32'hFFFFFFFF, 1, 0, 1, "SD_028_size");
    issue(0, 2, 0, 12'h028, 0, 1, 32'hDEAD55EF, 0, "LW_028c");

    for (int i = 0; i < 8; i++)
      issue(1, 2, 0, 12'(12'h040 + 4*i), 32'(i + 1), 0, 0, 0, "SW_b2b");
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      issue(0, 2, 0, 12'(12'h040 + 4*i), 0, 1, 32'(i + 1), 0, "LW_b2b");

    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)),
            32'($urandom), 0, 0, 0, "rand");
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // reset with one response showing and one load still in flight
    issue(0, 2, 0, 12'h028, 0, 0, 0, 0, "inflight1");
    issue(0, 2, 0, 12'h040, 0, 0, 0, 0, "inflight2");
    @(posedge clk);
    #1;
    check("pre-reset rsp_valid", 64'(bus.rsp_valid), 64'd1);
    reset_n = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    check("reset rsp_valid drop", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("reinit");
`ifdef DATA_MEM_INIT_SWEEP_EN
    issue(0, 2, 0, 12'h028, 0, 1, 32'h0, 0, "LW_028_swept");
`else
    issue(0, 2, 0, 12'h028, 0, 0, 0, 0, "LW_028_kept");
`endif
    issue(0, 2, 0, 12'h040, 0, 0, 0, 0, "LW_040_after");

    repeat (RD_LAT + 3) @(posedge clk);
    #1;
    check("pending responses", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_ls.md
# data_mem_ls

Pipelined load/store data memory for the multi-cycle and pipelined cores: the parametrised successor to the single-cycle word memory. It accepts one byte-addressed request per cycle over a valid/ready handshake and supports byte, half, word and (WIDTH=64) double sub-word accesses. Loads are sign- or zero-extended, and misaligned accesses are flagged. Every request returns exactly one in-order response after a fixed, configurable read latency.

## Interface
- WIDTH, 32, data word width in bits; 32 or 64 only.
- DEPTH, 1024, words of storage; power of two, at least 2.
- RD_LAT, 1, request-to-response latency in cycles; 1..4.
- Derived: BYTES = WIDTH/8; ADDR_W = $clog2(DEPTH) + $clog2(BYTES).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts requests.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  WIDTH  store data, right-aligned (bits [8·2^size−1:0] used).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  WIDTH  load result, right-aligned and extended; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal size.

## Operation
- Accept = req_valid && req_ready. There is no response backpressure; the consumer must always take rsp.
- States:
  - INIT: clear sweep, req_ready = 0.
  - RUN: req_ready = 1.
- Transitions:
  - Async reset forces INIT and sweep counter = 0.
  - INIT writes 0 to word[counter] each cycle and increments the counter.
  - At counter == DEPTH−1 the block writes the last word, then enters RUN next cycle. The counter does not wrap.
- Word index = req_addr[ADDR_W−1:$clog2(BYTES)]; lane offset = req_addr[$clog2(BYTES)−1:0].
- Error when:
  - the lane offset is not a multiple of 2^req_size, or
  - 2^req_size > BYTES (size 3 with WIDTH=32).
  - An errored store writes nothing; an errored load returns rdata 0. Both produce rsp_err = 1.
- Store: writes only the 2^size byte lanes starting at the lane offset, little-endian, at the accepting edge. Other lanes are unchanged.
- Load: reads the word at the accepting edge, extracts the lanes at the offset, then extends to WIDTH according to req_unsigned. Size == BYTES ignores req_unsigned.
- A load accepted the cycle after a store to the same word sees the new data. Only one request is accepted per cycle, so there is no same-cycle hazard.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All RD_LAT pipeline valid bits = 0.
- With DATA_MEM_INIT_SWEEP_EN, req_ready first goes high DEPTH+1 cycles after the first rising edge following reset release.
- Response latency: rsp_valid is high exactly RD_LAT cycles after the accepting edge, for one cycle. This applies to loads and stores.
- Throughput: one request per cycle sustained. Responses come back in acceptance order, back-to-back.
- rsp_rdata and rsp_err update only with rsp_valid and hold their last value otherwise.
- Reset asserted mid-stream:
  - all in-flight responses are dropped and rsp_valid falls immediately (async);
  - stores already committed are then cleared by the sweep.
- req_valid during INIT is ignored; no response is generated.

## Configuration
- DATA_MEM_INIT_SWEEP_EN defined:
  - reset runs the INIT clear sweep;
  - memory reads 0 everywhere after init.
- Not defined:
  - no INIT state and no sweep counter;
  - req_ready = 1 from the first rising edge after reset release;
  - memory contents are not cleared by reset (X in simulation until written).

## Test plan
All scenarios use WIDTH=32, DEPTH=1024, RD_LAT=2, DATA_MEM_INIT_SWEEP_EN defined.
- Reset release -> req_ready low for 1024 cycles, then high; LW 0x000 and LW 0xFFC -> rsp_rdata 0x00000000, rsp_err 0.
- SW 0x028 = 0xDEADBEEF, then LW 0x028 on the next cycle -> rsp_valid at +2 and +3 cycles; load returns 0xDEADBEEF.
- After the store above, run SB 0x029 = 0x55, then:
  - LW 0x028 -> 0xDEAD55EF;
  - LB 0x02B -> 0xFFFFFFDE;
  - LBU 0x02B -> 0x000000DE;
  - LH 0x02A -> 0xFFFFDEAD.
- SW 0x02A, LH 0x029, and size 3 at 0x030 -> each rsp_err 1, rdata 0; LW 0x028 is unchanged afterwards.
- 8 back-to-back LW at 0x040..0x05C (preloaded 1..8) -> 8 consecutive rsp_valid cycles returning 1..8 in order.
- Assert reset_n low with 2 loads in flight -> rsp_valid 0 immediately, no late responses, sweep restarts; LW 0x028 after init -> 0.
